// File: rtl/multfu_radix.sv
// Iterative radix-2^BITS_PER_CYCLE multiply unit with a one-entry result stage
// that serves independent CDB and ROB grants.
module multfu_radix #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter int ROBID_W        = 4,
    parameter int FLAGS_W        = 8,
    parameter int NOCDB_BIT      = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     input_transmit,
    input  logic [7:0]               operand,
    input  logic [1:0][WIDTH-1:0]    depvals,
    input  logic [7:0]               wbs,
    input  logic [FLAGS_W-1:0]       flags,
    input  logic [ROBID_W-1:0]       robid,
    input  logic                     cdb_transmit,
    output logic                     cdb_transmit_out,
    output logic [ROBID_W-1:0]       cdb_id,
    output logic [WIDTH-1:0]         cdb_val,
    input  logic                     rob_transmit,
    output logic [ROBID_W-1:0]       robid_out,
    output logic [FLAGS_W-1:0]       flags_out,
    output logic [7:0]               wbs_out,
    output logic [WIDTH-1:0]         value_out,
    output logic                     rob_transmit_out,
    output logic                     busy
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(N + 1);

    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [W2-1:0]      mcand, acc, acc_nxt, pp, fix;
    logic [WIDTH-1:0]   mplier, corr, result;
    logic               b_neg;
    logic [1:0]         mode;
    logic [7:0]         wbs_q;
    logic [FLAGS_W-1:0] flags_q;
    logic [ROBID_W-1:0] tag_q, tag_out;
    logic [WIDTH-1:0]   res_out;
    logic [CNT_W-1:0]   cnt;
    logic               last, free_next, load;
    logic               pend_cdb, pend_rob;
    logic               unused_opcode;

    assign unused_opcode = ^operand[7:2];

    // b is consumed as an unsigned WIDTH-bit value; a negative sign-extended b
    // contributes -a*2^WIDTH, folded into the final CALC cycle.
    assign pp      = mcand * W2'(mplier[BITS_PER_CYCLE-1:0]);
    assign last    = (cnt == CNT_W'(N - 1));
    assign fix     = (last && b_neg) ? {corr, {WIDTH{1'b0}}} : '0;
    assign acc_nxt = acc + pp - fix;
    assign result  = (mode == 2'b00) ? acc[WIDTH-1:0] : acc[W2-1:WIDTH];

    assign free_next = (!pend_cdb || cdb_transmit) && (!pend_rob || rob_transmit);
    assign load      = (state == DONE) && free_next;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (input_transmit) state_nxt = CALC;
            CALC:    if (last)           state_nxt = DONE;
            DONE:    if (free_next)      state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand   <= '0;
            mplier  <= '0;
            corr    <= '0;
            b_neg   <= 1'b0;
            mode    <= 2'b00;
            wbs_q   <= '0;
            flags_q <= '0;
            tag_q   <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else if (state == IDLE && input_transmit) begin
            // operand[0] set for MULH/MULHSU: a is signed
            mcand   <= {{WIDTH{operand[0] & depvals[0][WIDTH-1]}}, depvals[0]};
            mplier  <= depvals[1];
            corr    <= depvals[0];
            b_neg   <= (operand[1:0] == 2'b01) && depvals[1][WIDTH-1];
            mode    <= operand[1:0];
            wbs_q   <= wbs;
            flags_q <= flags;
            tag_q   <= robid;
            acc     <= '0;
            cnt     <= '0;
        end else if (state == CALC) begin
            acc     <= acc_nxt;
            mcand   <= mcand << BITS_PER_CYCLE;
            mplier  <= mplier >> BITS_PER_CYCLE;
            cnt     <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_cdb  <= 1'b0;
            pend_rob  <= 1'b0;
            tag_out   <= '0;
            res_out   <= '0;
            flags_out <= '0;
            wbs_out   <= '0;
        end else if (load) begin
            pend_rob  <= 1'b1;
            pend_cdb  <= ~flags_q[NOCDB_BIT];
            tag_out   <= tag_q;
            res_out   <= result;
            flags_out <= flags_q;
            wbs_out   <= wbs_q;
        end else begin
            if (cdb_transmit) pend_cdb <= 1'b0;
            if (rob_transmit) pend_rob <= 1'b0;
        end
    end

    assign cdb_transmit_out = pend_cdb;
    assign rob_transmit_out = pend_rob;
    assign cdb_id           = tag_out;
    assign robid_out        = tag_out;
    assign cdb_val          = res_out;
    assign value_out        = res_out;

endmodule

// File: tb/tb_multfu_radix.sv
// Directed bench for multfu_radix: mode table across four radices, a 16-bit
// instance, back-pressure, no-CDB and mid-op reset sequences.
module tb_multfu_radix;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_tx;
    logic [7:0]           operand;
    logic [1:0][7:0]      dv;
    logic [1:0][15:0]     dv16;
    logic [7:0]           wbs;
    logic [7:0]           flags;
    logic [3:0]           robid;
    logic                 cdb_g, rob_g;

    logic                 cdb_req[4];
    logic [3:0]           cdb_id[4];
    logic [7:0]           cdb_val[4];
    logic [3:0]           robid_o[4];
    logic [7:0]           flags_o[4];
    logic [7:0]           wbs_o[4];
    logic [7:0]           val_o[4];
    logic                 rob_req[4];
    logic                 busy[4];

    logic                 cdb_req16, rob_req16, busy16;
    logic [3:0]           cdb_id16, robid_o16;
    logic [15:0]          cdb_val16, val_o16;
    logic [7:0]           flags_o16, wbs_o16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        multfu_radix #(.WIDTH(8), .BITS_PER_CYCLE(1 << g)) u_dut (
            .clk(clk), .rst(rst), .input_transmit(in_tx), .operand(operand),
            .depvals(dv), .wbs(wbs), .flags(flags), .robid(robid),
            .cdb_transmit(cdb_g), .cdb_transmit_out(cdb_req[g]),
            .cdb_id(cdb_id[g]), .cdb_val(cdb_val[g]),
            .rob_transmit(rob_g), .robid_out(robid_o[g]), .flags_out(flags_o[g]),
            .wbs_out(wbs_o[g]), .value_out(val_o[g]),
            .rob_transmit_out(rob_req[g]), .busy(busy[g])
        );
    end

    multfu_radix #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
        .clk(clk), .rst(rst), .input_transmit(in_tx), .operand(operand),
        .depvals(dv16), .wbs(wbs), .flags(flags), .robid(robid),
        .cdb_transmit(cdb_g), .cdb_transmit_out(cdb_req16),
        .cdb_id(cdb_id16), .cdb_val(cdb_val16),
        .rob_transmit(rob_g), .robid_out(robid_o16), .flags_out(flags_o16),
        .wbs_out(wbs_o16), .value_out(val_o16),
        .rob_transmit_out(rob_req16), .busy(busy16)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  exp;
        logic [15:0] exp16;   // 16-bit unit always sees 0xFFFF x 0xFFFF
    } vec_t;

    vec_t vt[10];
    int   exp_lat[4] = '{9, 5, 3, 2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] tag, input logic [7:0] fl);
        operand = {6'd0, m};
        dv[0]   = a;
        dv[1]   = b;
        robid   = tag;
        flags   = fl;
        wbs     = {4'hA, tag};
        in_tx   = 1'b1;
        tick();
        in_tx   = 1'b0;
    endtask

    task automatic wait_req0();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!rob_req[0] && n < 40);
        chk("req_timeout", {31'd0, rob_req[0]}, 32'd1);
    endtask

    initial begin
        int  lat[4];
        int  lat16;
        int  n;
        logic seen;

        vt[0] = '{2'b00, 8'd13,  8'd11,  8'h8F, 16'h0001};
        vt[1] = '{2'b01, 8'hFD,  8'h05,  8'hFF, 16'h0000};
        vt[2] = '{2'b10, 8'hFF,  8'hFF,  8'hFE, 16'hFFFE};
        vt[3] = '{2'b11, 8'hFF,  8'hFF,  8'hFF, 16'hFFFF};
        vt[4] = '{2'b00, 8'hFF,  8'hFF,  8'h01, 16'h0001};
        vt[5] = '{2'b01, 8'h80,  8'h80,  8'h40, 16'h0000};
        vt[6] = '{2'b01, 8'h7F,  8'h80,  8'hC0, 16'h0000};
        vt[7] = '{2'b11, 8'h80,  8'h80,  8'hC0, 16'hFFFF};
        vt[8] = '{2'b10, 8'h80,  8'h80,  8'h40, 16'hFFFE};
        vt[9] = '{2'b00, 8'h00,  8'h37,  8'h00, 16'h0001};

        rst = 1'b0; in_tx = 1'b0; operand = '0; dv = '0; wbs = '0; flags = '0;
        robid = '0; cdb_g = 1'b0; rob_g = 1'b0;
        dv16 = {16'hFFFF, 16'hFFFF};
        #12;
        chk("rst_busy",    {31'd0, busy[0]}, 32'd0);
        chk("rst_rob_req", {31'd0, rob_req[0]}, 32'd0);
        chk("rst_cdb_req", {31'd0, cdb_req[0]}, 32'd0);
        chk("rst_value",   {24'd0, val_o[0]}, 32'd0);
        rst = 1'b1;
        cdb_g = 1'b1; rob_g = 1'b1;
        tick();

        // mode table, grants tied high
        for (int i = 0; i < 10; i++) begin
            dispatch(vt[i].mode, vt[i].a, vt[i].b, 4'(i + 1), 8'h00);
            chk("busy_after_accept", {31'd0, busy[0]}, 32'd1);
            for (int g = 0; g < 4; g++) lat[g] = 0;
            lat16 = 0;
            n = 0;
            while (lat[0] == 0 && n < 20) begin
                tick();
                n++;
                for (int g = 0; g < 4; g++)
                    if (rob_req[g] && lat[g] == 0) lat[g] = n;
                if (rob_req16 && lat16 == 0) lat16 = n;
            end
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("v%0d_lat_bpc%0d", i, 1 << g), lat[g], exp_lat[g]);
                chk($sformatf("v%0d_val_bpc%0d", i, 1 << g), {24'd0, val_o[g]}, {24'd0, vt[i].exp});
            end
            chk($sformatf("v%0d_lat_w16", i), lat16, 5);
            chk($sformatf("v%0d_val_w16", i), {16'd0, val_o16}, {16'd0, vt[i].exp16});
            chk("cdb_val",   {24'd0, cdb_val[0]}, {24'd0, vt[i].exp});
            chk("cdb_req",   {31'd0, cdb_req[0]}, 32'd1);
            chk("robid_out", {28'd0, robid_o[0]}, 32'(i + 1));
            chk("cdb_id",    {28'd0, cdb_id[0]}, 32'(i + 1));
            chk("wbs_out",   {24'd0, wbs_o[0]}, {24'd0, 4'hA, 4'(i + 1)});
            chk("busy_done", {31'd0, busy[0]}, 32'd0);
            tick();
            chk("rob_req_1cyc", {31'd0, rob_req[0]}, 32'd0);
            chk("cdb_req_1cyc", {31'd0, cdb_req[0]}, 32'd0);
            chk("val_kept",     {24'd0, val_o[0]}, {24'd0, vt[i].exp});
        end

        // back-pressure: A held in the stage, B parked in DONE
        cdb_g = 1'b0; rob_g = 1'b0;
        dispatch(2'b00, 8'd13, 8'd11, 4'd3, 8'h00);
        wait_req0();
        dispatch(2'b10, 8'hFF, 8'hFF, 4'd5, 8'h00);
        repeat (12) tick();
        chk("bp_busy",    {31'd0, busy[0]}, 32'd1);
        chk("bp_val_A",   {24'd0, val_o[0]}, 32'h8F);
        chk("bp_tag_A",   {28'd0, robid_o[0]}, 32'd3);
        chk("bp_cdb_req", {31'd0, cdb_req[0]}, 32'd1);
        rob_g = 1'b1; tick(); rob_g = 1'b0;
        chk("bp_rob_clr",  {31'd0, rob_req[0]}, 32'd0);
        chk("bp_cdb_hold", {31'd0, cdb_req[0]}, 32'd1);
        chk("bp_busy2",    {31'd0, busy[0]}, 32'd1);
        repeat (3) tick();
        chk("bp_val_A2",   {24'd0, cdb_val[0]}, 32'h8F);
        cdb_g = 1'b1; tick(); cdb_g = 1'b0;
        chk("bp_val_B",   {24'd0, val_o[0]}, 32'hFE);
        chk("bp_tag_B",   {28'd0, cdb_id[0]}, 32'd5);
        chk("bp_B_rob",   {31'd0, rob_req[0]}, 32'd1);
        chk("bp_B_cdb",   {31'd0, cdb_req[0]}, 32'd1);
        chk("bp_B_idle",  {31'd0, busy[0]}, 32'd0);
        cdb_g = 1'b1; rob_g = 1'b1; tick();
        chk("bp_drain",   {30'd0, rob_req[0], cdb_req[0]}, 32'd0);

        // no-CDB flag: only the ROB grant frees the stage
        cdb_g = 1'b0; rob_g = 1'b0;
        dispatch(2'b00, 8'd7, 8'd9, 4'd9, 8'h80);
        seen = 1'b0;
        n = 0;
        while (!rob_req[0] && n < 20) begin
            tick();
            n++;
            seen |= cdb_req[0];
        end
        chk("nocdb_rob_req", {31'd0, rob_req[0]}, 32'd1);
        chk("nocdb_cdb_low", {31'd0, seen | cdb_req[0]}, 32'd0);
        chk("nocdb_val",     {24'd0, val_o[0]}, 32'h3F);
        chk("nocdb_flags",   {24'd0, flags_o[0]}, 32'h80);
        dispatch(2'b10, 8'h10, 8'h20, 4'hA, 8'h00);
        repeat (12) tick();
        chk("nocdb_wait", {31'd0, busy[0]}, 32'd1);
        rob_g = 1'b1; tick(); rob_g = 1'b0;
        chk("nocdb_next_val", {24'd0, val_o[0]}, 32'h02);
        chk("nocdb_next_tag", {28'd0, robid_o[0]}, 32'hA);
        chk("nocdb_next_cdb", {31'd0, cdb_req[0]}, 32'd1);
        chk("nocdb_next_idle", {31'd0, busy[0]}, 32'd0);
        cdb_g = 1'b1; rob_g = 1'b1; tick();

        // reset in the middle of CALC
        dispatch(2'b00, 8'd13, 8'd11, 4'd6, 8'h00);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("mrst_busy",  {31'd0, busy[0]}, 32'd0);
        chk("mrst_reqs",  {30'd0, rob_req[0], cdb_req[0]}, 32'd0);
        chk("mrst_val",   {24'd0, val_o[0]}, 32'd0);
        chk("mrst_tag",   {28'd0, robid_o[0]}, 32'd0);
        #2 rst = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            seen |= rob_req[0] | cdb_req[0] | busy[0];
        end
        chk("mrst_quiet", {31'd0, seen}, 32'd0);
        dispatch(2'b01, 8'hFD, 8'h05, 4'd7, 8'h00);
        wait_req0();
        chk("mrst_new_val", {24'd0, val_o[0]}, 32'hFF);
        chk("mrst_new_tag", {28'd0, robid_o[0]}, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
